// File: rtl/ones_count_arbiter_if.sv
// Request/result bundle between NUM_REQ producers, the shared ones-count
// datapath and a single result consumer.
interface ones_count_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_SIZE    = 2,
  parameter int WORD_SIZE  = 4,
  parameter int COUNT_SIZE = 3
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic                         res_valid;
  logic [COUNT_SIZE-1:0]        res_count;
  logic [ID_SIZE-1:0]           res_id;
  logic                         res_ready;
  logic                         busy;

  // master: producers plus consumer; slave: the arbiter itself
  modport master (
    output req, req_data, res_ready,
    input  gnt, res_valid, res_count, res_id, busy
  );

  modport slave (
    input  req, req_data, res_ready,
    output gnt, res_valid, res_count, res_id, busy
  );
endinterface

// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter sharing one serial shift-and-add ones counter among
// NUM_REQ requesters. Define COUNT_ARB_FIXED_PRIORITY_EN for lowest-index-wins.
module ones_count_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_SIZE    = 2,
  parameter int WORD_SIZE  = 4,
  parameter int COUNT_SIZE = 3
) (
  input logic                clk,
  input logic                reset,
  ones_count_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESULT} state_e;

  state_e                state_q, state_d;
  logic [WORD_SIZE-1:0]  shreg_q, shreg_d, shreg_nxt;
  logic [COUNT_SIZE-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  res_valid_q, res_valid_d;
  logic [COUNT_SIZE-1:0] res_count_q, res_count_d;
  logic [ID_SIZE-1:0]    res_id_q, res_id_d;
  logic                  win_found;
  logic [ID_SIZE-1:0]    win_id;
  logic [WORD_SIZE-1:0]  win_data;

`ifdef COUNT_ARB_FIXED_PRIORITY_EN
  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_found = 1'b1;
        win_id    = ID_SIZE'(i);
      end
    end
  end
`else
  logic [ID_SIZE-1:0] ptr_q, ptr_d;
  int                 idx;

  // Offsets scanned from far to near so the requester closest after the
  // pointer wins; the pointer itself comes last.
  // NOTE: every variable gets a default before any conditional write, so no
  // latch can be inferred from a path that leaves it unassigned.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_SIZE'(idx);
      end
    end
  end

  assign ptr_d = (state_q == S_IDLE && win_found) ? win_id : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= ID_SIZE'(NUM_REQ - 1);
    else       ptr_q <= ptr_d;
  end
`endif

  assign win_data  = bus.req_data[int'(win_id)*WORD_SIZE +: WORD_SIZE];
  assign cnt_inc   = cnt_q + COUNT_SIZE'(shreg_q[0]);
  assign shreg_nxt = shreg_q >> 1;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    res_valid_d = res_valid_q;
    res_count_d = res_count_q;
    res_id_d    = res_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d[win_id] = 1'b1;
          res_id_d      = win_id;
          shreg_d       = win_data;
          cnt_d         = '0;
          if (win_data != '0) begin
            state_d = S_SHIFT;
          end else begin
            state_d     = S_RESULT;
            res_valid_d = 1'b1;
            res_count_d = '0;
          end
        end
      end
      S_SHIFT: begin
        cnt_d   = cnt_inc;
        shreg_d = shreg_nxt;
        // Stop as soon as no ones remain above the bit just counted.
        if (shreg_nxt == '0) begin
          res_count_d = cnt_inc;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_count = res_count_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ones_count_arbiter.sv
// Directed bench for ones_count_arbiter: stimulus pushes expected grants and
// results into queues, a negedge monitor pops and compares them.
module tb_ones_count_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ID_SIZE    = 2;
  localparam int WORD_SIZE  = 4;
  localparam int COUNT_SIZE = 3;

  typedef struct {
    int id;
    int cnt;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  bit   drop_on_gnt;
  int   n_total = 0;
  int   n_bad   = 0;

  int   exp_gnt[$];
  res_t exp_res[$];
  logic [NUM_REQ-1:0] prev_gnt;

  ones_count_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ID_SIZE(ID_SIZE),
    .WORD_SIZE(WORD_SIZE), .COUNT_SIZE(COUNT_SIZE)
  ) bus ();

  ones_count_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_SIZE(ID_SIZE),
    .WORD_SIZE(WORD_SIZE), .COUNT_SIZE(COUNT_SIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic void push_res(input int id, input int cnt);
    res_t r;
    r.id  = id;
    r.cnt = cnt;
    exp_res.push_back(r);
  endfunction

  // Monitor: samples mid-cycle while inputs (driven 1ns after posedge) are stable.
  always @(negedge clk) begin
    if (reset) begin
      prev_gnt = '0;
    end else begin
      if (bus.gnt != '0) begin
        check("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
        check("gnt_back_to_back", 32'(prev_gnt), 32'd0);
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 32'd0);
        else                     check("gnt_order", 32'(bus.gnt), 32'(1 << exp_gnt.pop_front()));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_res.size() == 0) begin
          check("res_unexpected", 32'(bus.res_valid), 32'd0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("res_id", 32'(bus.res_id), 32'(r.id));
          check("res_count", 32'(bus.res_count), 32'(r.cnt));
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (drop_on_gnt) bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic wait_gnt();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      if (bus.gnt != '0) ok = 1'b1;
    end
    if (!ok) timeout("wait_gnt");
  endtask

  task automatic wait_valid();
    bit ok;
    ok = bus.res_valid;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      if (bus.res_valid) ok = 1'b1;
    end
    if (!ok) timeout("wait_valid");
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset         = 1'b1;
    drop_on_gnt   = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
    cyc();
    cyc();
    check("rst_outputs", 32'({bus.gnt, bus.res_valid, bus.res_count, bus.res_id, bus.busy}), 32'd0);
    reset = 1'b0;

    // 1: single request, 0xB -> count 3 after 4 cycles
    drop_on_gnt  = 1'b1;
    bus.req_data = 16'h00B0;
    exp_gnt.push_back(1);
    push_res(1, 3);
    bus.req = 4'b0010;
    wait_gnt();
    check("t1_gnt", 32'(bus.gnt), 32'h2);
    cyc();
    check("t1_gnt_pulse", 32'(bus.gnt), 32'h0);
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check("t1_latency", 32'(lat), 32'd4);
    cyc();
    check("t1_valid_drop", 32'(bus.res_valid), 32'd0);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // 2: zero word -> gnt and res_valid together
    bus.req_data = 16'h0000;
    exp_gnt.push_back(2);
    push_res(2, 0);
    bus.req = 4'b0100;
    wait_gnt();
    check("t2_gnt", 32'(bus.gnt), 32'h4);
    check("t2_valid_with_gnt", 32'(bus.res_valid), 32'd1);
    cyc();
    check("t2_valid_drop", 32'(bus.res_valid), 32'd0);

    // 3: all four held, round-robin order 0,1,2,3,0,1
    do_reset();
    drop_on_gnt  = 1'b0;
    bus.req_data = 16'hB5AF;
    foreach (exp_gnt[i]) check("t3_queue_clean", 32'(exp_gnt.size()), 32'd0);
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    exp_gnt.push_back(3); exp_gnt.push_back(0); exp_gnt.push_back(1);
    push_res(0, 4); push_res(1, 2); push_res(2, 2);
    push_res(3, 3); push_res(0, 4); push_res(1, 2);
    bus.req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_gnt();
      if (n == 5) bus.req = '0;
      wait_valid();
      cyc();
      check("t3_idle_gap", 32'({bus.busy, bus.gnt}), 32'd0);
    end

    // 4: back-pressure holds the result; pending req[3] waits
    do_reset();
    drop_on_gnt   = 1'b1;
    bus.res_ready = 1'b0;
    bus.req_data  = 16'h6007;
    exp_gnt.push_back(0);
    exp_gnt.push_back(3);
    push_res(0, 3);
    push_res(3, 2);
    bus.req = 4'b1001;
    wait_gnt();
    check("t4_first_gnt", 32'(bus.gnt), 32'h1);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      check("t4_hold", 32'({bus.res_valid, bus.res_count, bus.res_id, bus.busy, bus.gnt}),
            32'({1'b1, 3'd3, 2'd0, 1'b1, 4'b0000}));
      cyc();
    end
    bus.res_ready = 1'b1;
    cyc();
    check("t4_idle_gap", 32'({bus.busy, bus.gnt}), 32'd0);
    cyc();
    check("t4_second_gnt", 32'(bus.gnt), 32'h8);
    wait_valid();
    cyc();

    // 5: reset mid-SHIFT aborts the word; req[0] wins first afterwards
    do_reset();
    drop_on_gnt  = 1'b1;
    bus.req_data = 16'h000F;
    exp_gnt.push_back(0);
    bus.req = 4'b0001;
    wait_gnt();
    cyc();
    reset = 1'b1;
    cyc();
    check("t5_reset_outputs", 32'({bus.gnt, bus.res_valid, bus.res_count, bus.res_id, bus.busy}), 32'd0);
    bus.req_data = 16'h0103;
    exp_gnt.push_back(0);
    exp_gnt.push_back(2);
    push_res(0, 2);
    push_res(2, 1);
    bus.req = 4'b0101;
    reset   = 1'b0;
    wait_gnt();
    check("t5_first_gnt", 32'(bus.gnt), 32'h1);
    wait_valid();
    cyc();
    wait_gnt();
    check("t5_second_gnt", 32'(bus.gnt), 32'h4);
    wait_valid();
    cyc();

    // 6: req[0] and req[3] held; alternation unless fixed priority
    do_reset();
    drop_on_gnt  = 1'b0;
    bus.req_data = 16'h2001;
`ifdef COUNT_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(0);
      push_res(0, 1);
    end
`else
    for (int i = 0; i < 2; i++) begin
      exp_gnt.push_back(0);
      exp_gnt.push_back(3);
      push_res(0, 1);
      push_res(3, 1);
    end
`endif
    bus.req = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      wait_gnt();
      if (n == 3) bus.req = '0;
      wait_valid();
      cyc();
    end

    repeat (5) cyc();
    check("sb_gnt_drained", 32'(exp_gnt.size()), 32'd0);
    check("sb_res_drained", 32'(exp_res.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
